mioc_dram_seq: RTL and testbench



---
 rtl/mioc_dram_pkg.sv | 29 ++
 rtl/mioc_ref_timer.sv | 60 ++++++
 rtl/mioc_dram_seq.sv | 172 +++++++++++++++++
 tb/tb_mioc_dram_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mioc_dram_pkg.sv
// Shared types and defaults for the MIOC DRAM strobe sequencer.
// Latency: none. This file holds type and constant definitions only.
// Backpressure: none.
package mioc_dram_pkg;

  // Default strobe timing, in B_PHI cycles
  localparam int T_RM_DEF         = 1;
  localparam int T_MC_DEF         = 1;
  localparam int T_PRE_DEF        = 1;
  localparam int ROW_BITS_DEF     = 7;
  localparam int REF_INTERVAL_DEF = 64;
  localparam int MAX_DEFER_DEF    = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACT_R,
    ST_ACT_M,
    ST_ACT_C,
    ST_EREF,
    ST_IREF,
    ST_PRE
  } dram_state_t;

  // Bank-select width: at least one bit, even when there is a single bank
  function automatic int bs_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mioc_ref_timer.sv
// Refresh bookkeeping: interval down-counter, refresh-due flag, defer counter, refresh row.
// Latency: ref_due rises one clock after the timer reaches zero. i_done takes effect on the next edge.
// Backpressure: none. A due refresh waits until the sequencer pulses i_done.
module mioc_ref_timer #(
  parameter int REF_INTERVAL = 64,
  parameter int MAX_DEFER    = 8,
  parameter int ROW_BITS     = 7
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_done,
  input  logic                i_inc_row,
  input  logic                i_in_ref,
  output logic                o_ref_due,
  output logic                o_force,
  output logic [ROW_BITS-1:0] o_ref_row
);

  localparam int TW = $clog2(REF_INTERVAL);
  localparam int DW = $clog2(MAX_DEFER + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(REF_INTERVAL - 1);
  localparam logic [DW-1:0] DEF_MAX  = DW'(MAX_DEFER);

  logic [TW-1:0]       r_tmr;
  logic                r_due;
  logic [DW-1:0]       r_defer;
  logic [ROW_BITS-1:0] r_row;

  // Interval timer: counts down to zero and parks there until a refresh completes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               r_tmr <= TMR_LOAD;
    else if (i_done)         r_tmr <= TMR_LOAD;
    else if (r_tmr != '0)    r_tmr <= r_tmr - TW'(1);
  end

  // Refresh-due flag: raised by an expired timer, dropped by any completed refresh
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)               r_due <= 1'b0;
    else if (i_done)         r_due <= 1'b0;
    else if (r_tmr == '0)    r_due <= 1'b1;
  end

  // Defer counter: measures how long a due refresh has yielded to CPU traffic
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                           r_defer <= '0;
    else if (i_done)                                     r_defer <= '0;
    else if (r_due && !i_in_ref && (r_defer != DEF_MAX)) r_defer <= r_defer + DW'(1);
  end

  // Refresh row: advances only after an internal refresh, because external refresh uses the CPU row
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                     r_row <= '0;
    else if (i_done && i_inc_row)  r_row <= r_row + ROW_BITS'(1);
  end

  assign o_ref_due = r_due;
  assign o_force   = r_due && (r_defer >= DEF_MAX);
  assign o_ref_row = r_row;

endmodule

// File: rtl/mioc_dram_seq.sv
// DRAM RAS/MUX/CAS strobe sequencer for the MIOC, with an internal refresh engine.
// Latency: RAS_N falls on the accepting edge, MUX after T_RM clocks, CAS_N after T_RM+T_MC clocks.
// Backpressure: WAIT_N stalls a CPU access that collides with an internal refresh or its precharge.
module mioc_dram_seq
  import mioc_dram_pkg::*;
#(
  parameter int NUM_BANKS    = 2,
  parameter int T_RM         = T_RM_DEF,
  parameter int T_MC         = T_MC_DEF,
  parameter int T_PRE        = T_PRE_DEF,
  parameter int ROW_BITS     = ROW_BITS_DEF,
  parameter int REF_INTERVAL = REF_INTERVAL_DEF,
  parameter int MAX_DEFER    = MAX_DEFER_DEF,
  localparam int BS_W        = bs_width(NUM_BANKS)
) (
  input  logic                 i_b_phi,
  input  logic                 i_rst,
  input  logic                 i_bmreq_n,
  input  logic                 i_brfsh_n,
  input  logic                 i_dma_n,
  input  logic                 i_mem_hit,
  input  logic [BS_W-1:0]      i_bank_sel,
  output logic                 o_ras_n,
  output logic                 o_mux,
  output logic [NUM_BANKS-1:0] o_cas_n,
  output logic                 o_wait_n,
  output logic                 o_ref_act,
  output logic [ROW_BITS-1:0]  o_ref_row
);

  localparam logic [3:0] LIM_RM  = 4'(T_RM - 1);
  localparam logic [3:0] LIM_MC  = 4'(T_MC - 1);
  localparam logic [3:0] LIM_REF = 4'(T_RM + T_MC - 1);
  localparam logic [3:0] LIM_PRE = 4'(T_PRE - 1);

  dram_state_t          r_state, w_nxt, w_pick;
  logic [3:0]           r_cnt, w_cnt_nxt;
  logic [BS_W-1:0]      r_bank;
  logic                 r_pre_iref;
  logic                 r_ras_n, r_mux, r_ref_act;
  logic [NUM_BANKS-1:0] r_cas_n, w_cas_dec;
  logic                 w_acc_req, w_ext_ref, w_done, w_inc_row, w_in_ref;
  logic                 w_ref_due, w_force;

  // While the 6801 owns the bus, Z80 refresh cycles are not trusted
  assign w_acc_req = !i_bmreq_n && i_brfsh_n && i_mem_hit;
  assign w_ext_ref = !i_bmreq_n && !i_brfsh_n && i_dma_n;
  assign w_in_ref  = (r_state == ST_IREF) || (r_state == ST_EREF);

  mioc_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL),
    .MAX_DEFER    (MAX_DEFER),
    .ROW_BITS     (ROW_BITS)
  ) u_ref (
    .i_clk     (i_b_phi),
    .i_rst     (i_rst),
    .i_done    (w_done),
    .i_inc_row (w_inc_row),
    .i_in_ref  (w_in_ref),
    .o_ref_due (w_ref_due),
    .o_force   (w_force),
    .o_ref_row (o_ref_row)
  );

  // Arbitration from idle: CPU refresh, then starved refresh, then access, then opportunistic refresh
  always_comb begin
    w_pick = ST_IDLE;
    if (w_ext_ref)      w_pick = ST_EREF;
    else if (w_force)   w_pick = ST_IREF;
    else if (w_acc_req) w_pick = ST_ACT_R;
    else if (w_ref_due) w_pick = ST_IREF;
  end

  // Next-state and cycle counter; the precharge exit arbitrates directly so held requests lose no clock
  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt + 4'd1;
    w_done    = 1'b0;
    w_inc_row = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_nxt     = w_pick;
        w_cnt_nxt = '0;
      end
      ST_ACT_R: begin
        if (i_bmreq_n)             begin w_nxt = ST_PRE;   w_cnt_nxt = '0; end
        else if (r_cnt == LIM_RM)  begin w_nxt = ST_ACT_M; w_cnt_nxt = '0; end
      end
      ST_ACT_M: begin
        if (i_bmreq_n)             begin w_nxt = ST_PRE;   w_cnt_nxt = '0; end
        else if (r_cnt == LIM_MC)  begin w_nxt = ST_ACT_C; w_cnt_nxt = '0; end
      end
      ST_ACT_C: begin
        w_cnt_nxt = r_cnt;
        if (i_bmreq_n)             begin w_nxt = ST_PRE;   w_cnt_nxt = '0; end
      end
      ST_EREF: begin
        w_cnt_nxt = r_cnt;
        if (i_bmreq_n) begin
          w_nxt     = ST_PRE;
          w_cnt_nxt = '0;
          w_done    = 1'b1;
        end
      end
      ST_IREF: begin
        if (r_cnt == LIM_REF) begin
          w_nxt     = ST_PRE;
          w_cnt_nxt = '0;
          w_done    = 1'b1;
          w_inc_row = 1'b1;
        end
      end
      ST_PRE: begin
        if (r_cnt == LIM_PRE) begin
          w_nxt     = w_pick;
          w_cnt_nxt = '0;
        end
      end
      default: begin
        w_nxt     = ST_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // State, counter, latched bank and refresh-precharge marker
  always_ff @(posedge i_b_phi or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bank     <= '0;
      r_pre_iref <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      if ((w_nxt == ST_ACT_R) && (r_state != ST_ACT_R)) r_bank <= i_bank_sel;
      r_pre_iref <= (w_nxt == ST_PRE) &&
                    ((r_state == ST_IREF) || ((r_state == ST_PRE) && r_pre_iref));
    end
  end

  // One-hot-low CAS for the latched bank; an out-of-range bank selects nothing
  always_comb begin
    w_cas_dec = '1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (int'(r_bank) == b) w_cas_dec[b] = 1'b0;
    end
  end

  // Strobes are registered from the next state so they change on the same edge as the state
  always_ff @(posedge i_b_phi or posedge i_rst) begin
    if (i_rst) begin
      r_ras_n   <= 1'b1;
      r_mux     <= 1'b0;
      r_cas_n   <= '1;
      r_ref_act <= 1'b0;
    end else begin
      r_ras_n   <= !((w_nxt == ST_ACT_R) || (w_nxt == ST_ACT_M) || (w_nxt == ST_ACT_C) ||
                     (w_nxt == ST_EREF)  || (w_nxt == ST_IREF));
      r_mux     <= (w_nxt == ST_ACT_M) || (w_nxt == ST_ACT_C);
      r_cas_n   <= (w_nxt == ST_ACT_C) ? w_cas_dec : '1;
      r_ref_act <= (w_nxt == ST_IREF);
    end
  end

  assign o_ras_n   = r_ras_n;
  assign o_mux     = r_mux;
  assign o_cas_n   = r_cas_n;
  assign o_ref_act = r_ref_act;
  assign o_wait_n  = !(w_acc_req && ((r_state == ST_IREF) || ((r_state == ST_PRE) && r_pre_iref)));

endmodule

// File: tb/tb_mioc_dram_seq.sv
module tb_mioc_dram_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bmreq_n = 1'b1, brfsh_n = 1'b1, dma_n = 1'b1, mem_hit = 1'b0;
  logic [0:0] bank_sel = 1'b0;
  logic       ras_n, mux, wait_n, ref_act;
  logic [1:0] cas_n;
  logic [6:0] ref_row;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_cas;
  logic [1:0] prev_cas = 2'b11;
  logic       prev_due = 1'b0, prev_ref = 1'b0;
  int cyc = 0, t_due = -1, t_ref = -1, n_pref = 0;

  mioc_dram_seq dut (
    .i_b_phi    (clk),
    .i_rst      (rst),
    .i_bmreq_n  (bmreq_n),
    .i_brfsh_n  (brfsh_n),
    .i_dma_n    (dma_n),
    .i_mem_hit  (mem_hit),
    .i_bank_sel (bank_sel),
    .o_ras_n    (ras_n),
    .o_mux      (mux),
    .o_cas_n    (cas_n),
    .o_wait_n   (wait_n),
    .o_ref_act  (ref_act),
    .o_ref_row  (ref_row)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every CAS assertion pops one expected bank pattern
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_cas = 2'b11;
    end else begin
      if (prev_cas == 2'b11 && cas_n != 2'b11) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL cas_unexpected: got %b required no CAS", cas_n);
        end else begin
          exp_cas = exp_q.pop_front();
          if (cas_n !== exp_cas || mux !== 1'b1 || ras_n !== 1'b0) begin
            bad++;
            $display("FAIL cas_scoreboard: got cas=%b mux=%b ras_n=%b required cas=%b mux=1 ras_n=0",
                     cas_n, mux, ras_n, exp_cas);
          end
        end
        if (dut.u_ref.r_due) n_pref++;
      end
      if (dut.u_ref.r_due && !prev_due) t_due = cyc;
      if (ref_act && !prev_ref) t_ref = cyc;
      prev_cas = cas_n;
    end
    prev_due = dut.u_ref.r_due;
    prev_ref = ref_act;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (ras_n !== 1'b1)   begin bad++; $display("FAIL rst_ras_n: got %b required 1", ras_n); end
    total++; if (mux !== 1'b0)     begin bad++; $display("FAIL rst_mux: got %b required 0", mux); end
    total++; if (cas_n !== 2'b11)  begin bad++; $display("FAIL rst_cas_n: got %b required 11", cas_n); end
    total++; if (wait_n !== 1'b1)  begin bad++; $display("FAIL rst_wait_n: got %b required 1", wait_n); end
    total++; if (ref_act !== 1'b0) begin bad++; $display("FAIL rst_ref_act: got %b required 0", ref_act); end
    total++; if (ref_row !== 7'd0) begin bad++; $display("FAIL rst_ref_row: got %0d required 0", ref_row); end
    total++; if (dut.u_ref.r_tmr !== 6'd63) begin bad++; $display("FAIL rst_timer: got %0d required 63", dut.u_ref.r_tmr); end
    total++; if (dut.u_ref.r_due !== 1'b0)  begin bad++; $display("FAIL rst_due: got %b required 0", dut.u_ref.r_due); end
    rst = 1'b0;
  endtask

  task automatic test_read();
    bmreq_n = 1'b0; mem_hit = 1'b1; bank_sel = 1'b1; exp_q.push_back(2'b01);
    @(negedge clk);  // edge 0
    total++; if (ras_n !== 1'b0 || mux !== 1'b0 || cas_n !== 2'b11)
      begin bad++; $display("FAIL read_e0: got ras_n=%b mux=%b cas=%b required 0 0 11", ras_n, mux, cas_n); end
    @(negedge clk);  // edge 1
    total++; if (mux !== 1'b1 || cas_n !== 2'b11)
      begin bad++; $display("FAIL read_e1: got mux=%b cas=%b required 1 11", mux, cas_n); end
    @(negedge clk);  // edge 2
    total++; if (cas_n !== 2'b01) begin bad++; $display("FAIL read_e2_cas: got %b required 01", cas_n); end
    total++; if (wait_n !== 1'b1) begin bad++; $display("FAIL read_wait_n: got %b required 1", wait_n); end
    repeat (3) @(negedge clk);
    bmreq_n = 1'b1;
    @(negedge clk);  // edge 6: release
    total++; if (ras_n !== 1'b1 || mux !== 1'b0 || cas_n !== 2'b11)
      begin bad++; $display("FAIL read_release: got ras_n=%b mux=%b cas=%b required 1 0 11", ras_n, mux, cas_n); end
    bmreq_n = 1'b0; bank_sel = 1'b0; exp_q.push_back(2'b10);
    @(negedge clk);  // edge 7: accepted as precharge ends
    total++; if (ras_n !== 1'b0) begin bad++; $display("FAIL read_b2b_accept: got ras_n=%b required 0", ras_n); end
    repeat (2) @(negedge clk);
    bmreq_n = 1'b1; mem_hit = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_early_release();
    bmreq_n = 1'b0; mem_hit = 1'b1; bank_sel = 1'b1;
    @(negedge clk);
    total++; if (ras_n !== 1'b0) begin bad++; $display("FAIL early_ras: got %b required 0", ras_n); end
    bmreq_n = 1'b1;
    @(negedge clk);
    total++; if (ras_n !== 1'b1 || mux !== 1'b0)
      begin bad++; $display("FAIL early_pre: got ras_n=%b mux=%b required 1 0", ras_n, mux); end
    repeat (2) @(negedge clk);
    total++; if (cas_n !== 2'b11) begin bad++; $display("FAIL early_no_cas: got %b required 11", cas_n); end
    mem_hit = 1'b0;
  endtask

  task automatic test_ext_ref();
    bmreq_n = 1'b0; brfsh_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (ras_n !== 1'b0 || mux !== 1'b0 || cas_n !== 2'b11)
        begin bad++; $display("FAIL eref_strobes[%0d]: got ras_n=%b mux=%b cas=%b required 0 0 11", i, ras_n, mux, cas_n); end
    end
    bmreq_n = 1'b1; brfsh_n = 1'b1;
    @(negedge clk);
    total++; if (ras_n !== 1'b1) begin bad++; $display("FAIL eref_exit: got ras_n=%b required 1", ras_n); end
    total++; if (dut.u_ref.r_tmr !== 6'd63) begin bad++; $display("FAIL eref_timer: got %0d required 63", dut.u_ref.r_tmr); end
    total++; if (ref_row !== 7'd0) begin bad++; $display("FAIL eref_row: got %0d required 0", ref_row); end
    @(negedge clk);
  endtask

  task automatic test_int_ref();
    logic [6:0] exp_row;
    int n, hi;
    exp_row = 7'd0;
    dma_n = 1'b0;
    for (int k = 0; k < 128; k++) begin
      n = 0;
      while (ref_act !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      total++;
      if (ref_act !== 1'b1) begin
        bad++; $display("FAIL iref_timeout[%0d]: got ref_act=%b required 1", k, ref_act);
        break;
      end
      total++; if (ras_n !== 1'b0 || mux !== 1'b0)
        begin bad++; $display("FAIL iref_strobes[%0d]: got ras_n=%b mux=%b required 0 0", k, ras_n, mux); end
      hi = 0;
      while (ref_act === 1'b1 && hi < 20) begin @(negedge clk); hi++; end
      total++; if (hi != 2) begin bad++; $display("FAIL iref_len[%0d]: got %0d required 2", k, hi); end
      exp_row = exp_row + 7'd1;
      total++; if (ref_row !== exp_row) begin bad++; $display("FAIL iref_row[%0d]: got %0d required %0d", k, ref_row, exp_row); end
    end
    total++; if (ref_row !== 7'd0) begin bad++; $display("FAIL iref_wrap: got %0d required 0", ref_row); end
    // A Z80 refresh cycle during DMA must not start a RAS-only refresh
    bmreq_n = 1'b0; brfsh_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (ras_n !== 1'b1) begin bad++; $display("FAIL dma_ignores_eref: got ras_n=%b required 1", ras_n); end
    bmreq_n = 1'b1; brfsh_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_collision();
    int n;
    n = 0;
    while (ref_act !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    total++; if (ref_act !== 1'b1) begin bad++; $display("FAIL coll_timeout: got ref_act=%b required 1", ref_act); end
    bmreq_n = 1'b0; mem_hit = 1'b1; bank_sel = 1'b1; exp_q.push_back(2'b01);
    #1;
    total++; if (wait_n !== 1'b0) begin bad++; $display("FAIL coll_wait_iref0: got %b required 0", wait_n); end
    @(negedge clk);
    total++; if (wait_n !== 1'b0 || ref_act !== 1'b1)
      begin bad++; $display("FAIL coll_wait_iref1: got wait_n=%b ref_act=%b required 0 1", wait_n, ref_act); end
    @(negedge clk);
    total++; if (wait_n !== 1'b0 || ref_act !== 1'b0 || ras_n !== 1'b1)
      begin bad++; $display("FAIL coll_wait_pre: got wait_n=%b ref_act=%b ras_n=%b required 0 0 1", wait_n, ref_act, ras_n); end
    @(negedge clk);
    total++; if (wait_n !== 1'b1 || ras_n !== 1'b0)
      begin bad++; $display("FAIL coll_access_start: got wait_n=%b ras_n=%b required 1 0", wait_n, ras_n); end
    repeat (2) @(negedge clk);
    total++; if (cas_n !== 2'b01) begin bad++; $display("FAIL coll_cas: got %b required 01", cas_n); end
    bmreq_n = 1'b1; mem_hit = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_access(input logic b, output bit saw_wait);
    int n;
    n = 0;
    saw_wait = 1'b0;
    bmreq_n = 1'b0; mem_hit = 1'b1; bank_sel = b;
    exp_q.push_back(b ? 2'b01 : 2'b10);
    #1;
    if (wait_n === 1'b0) saw_wait = 1'b1;
    @(negedge clk);
    while (cas_n === 2'b11 && n < 30) begin
      if (wait_n === 1'b0) saw_wait = 1'b1;
      @(negedge clk);
      n++;
    end
    total++; if (cas_n === 2'b11) begin bad++; $display("FAIL access_timeout: got cas=%b required a bank strobe", cas_n); end
    @(negedge clk);
    bmreq_n = 1'b1; mem_hit = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    bit sw, any_wait;
    any_wait = 1'b0;
    repeat (45) @(negedge clk);
    t_due = -1; t_ref = -1; n_pref = 0;
    for (int i = 0; i < 20 && t_ref < 0; i++) begin
      do_access(i % 2 == 1, sw);
      if (sw) any_wait = 1'b1;
    end
    total++; if (t_ref < 0 || t_due < 0)
      begin bad++; $display("FAIL starve_no_iref: got t_due=%0d t_ref=%0d required both set", t_due, t_ref); end
    total++; if ((t_ref - t_due) < 8 || (t_ref - t_due) > 14)
      begin bad++; $display("FAIL starve_defer: got %0d cycles required 8..14", t_ref - t_due); end
    total++; if (n_pref < 1) begin bad++; $display("FAIL starve_access_pref: got %0d accesses required >=1", n_pref); end
    total++; if (any_wait !== 1'b1) begin bad++; $display("FAIL starve_wait: got %b required 1", any_wait); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_async_reset();
    bmreq_n = 1'b0; mem_hit = 1'b1; bank_sel = 1'b0; exp_q.push_back(2'b10);
    repeat (3) @(negedge clk);
    total++; if (cas_n !== 2'b10) begin bad++; $display("FAIL arst_pre_cas: got %b required 10", cas_n); end
    #2 rst = 1'b1;
    #1;
    total++; if (ras_n !== 1'b1 || mux !== 1'b0 || cas_n !== 2'b11)
      begin bad++; $display("FAIL arst_strobes: got ras_n=%b mux=%b cas=%b required 1 0 11", ras_n, mux, cas_n); end
    @(negedge clk);
    bmreq_n = 1'b1; mem_hit = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (dut.u_ref.r_tmr !== 6'd63) begin bad++; $display("FAIL arst_timer: got %0d required 63", dut.u_ref.r_tmr); end
    total++; if (ref_row !== 7'd0) begin bad++; $display("FAIL arst_row: got %0d required 0", ref_row); end
    repeat (2) @(negedge clk);
    total++; if (ras_n !== 1'b1) begin bad++; $display("FAIL arst_idle: got ras_n=%b required 1", ras_n); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_early_release();
    test_ext_ref();
    test_int_ref();
    test_collision();
    test_starvation();
    test_async_reset();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
